// File: rtl/lii_stream_pkt_fifo.sv
// LII beat FIFO for any DEPTH >= 2: first-word fall-through, optional store-and-forward
// release, occupancy/packet counters, programmable almost-full and synchronous flush.
module lii_stream_pkt_fifo #(
    parameter int DW       = 256,
    parameter int SRC_W    = 8,
    parameter int DST_W    = 8,
    parameter int TYPE_W   = 2,
    parameter int DEPTH    = 4,
    parameter int PKT_MODE = 0,
    parameter int AFULL_TH = DEPTH - 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DW-1:0]     s_data,
    input  logic [DW/8-1:0]   s_keep,
    input  logic [DW/8-1:0]   s_strb,
    input  logic              s_last,
    input  logic [SRC_W-1:0]  s_src,
    input  logic [DST_W-1:0]  s_dst,
    input  logic [TYPE_W-1:0] s_type,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DW-1:0]     m_data,
    output logic [DW/8-1:0]   m_keep,
    output logic [DW/8-1:0]   m_strb,
    output logic              m_last,
    output logic [SRC_W-1:0]  m_src,
    output logic [DST_W-1:0]  m_dst,
    output logic [TYPE_W-1:0] m_type,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     pkt_count,
    output logic              almost_full
);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = DW + 2 * (DW / 8) + 1 + SRC_W + DST_W + TYPE_W;

    logic [BW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d, pkt_count_q, pkt_count_d;
    logic          draining_q, draining_d;
    logic          full, empty, push, pop;

    assign {m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type} = mem[rd_idx_q];

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        s_ready     = ~full & ~flush & ~rst;
        count       = count_q;
        pkt_count   = pkt_count_q;
        almost_full = (count_q >= CW'(AFULL_TH));
        // Full override lets packets longer than DEPTH drain; draining keeps their tail releasable.
        if (PKT_MODE != 0) begin
            m_valid = (pkt_count_q != '0) | full | (draining_q & ~empty);
        end else begin
            m_valid = ~empty;
        end
        push = s_valid & s_ready;
        pop  = m_valid & m_ready;

        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        draining_d = draining_q;
        if (push) begin
            wr_idx_d = (wr_idx_q == IW'(DEPTH - 1)) ? '0 : wr_idx_q + IW'(1);
        end
        if (pop) begin
            rd_idx_d   = (rd_idx_q == IW'(DEPTH - 1)) ? '0 : rd_idx_q + IW'(1);
            draining_d = ~m_last;
        end
        count_d     = count_q + CW'(push) - CW'(pop);
        pkt_count_d = pkt_count_q + CW'(push & s_last) - CW'(pop & m_last);

        if (flush) begin
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            count_d     = '0;
            pkt_count_d = '0;
            draining_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            draining_q  <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            draining_q  <= draining_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx_q] <= {s_data, s_keep, s_strb, s_last, s_src, s_dst, s_type};
        end
    end
endmodule

// File: tb/tb_lii_stream_pkt_fifo.sv
// Scoreboard bench for lii_stream_pkt_fifo: three configurations run side by side,
// each with directed scenarios followed by randomized traffic against a queue model.
module tb_lii_stream_pkt_fifo;
    localparam int DW   = 32;
    localparam int NCFG = 3;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] k;
        logic [DW/8-1:0] s;
        logic            l;
        logic [7:0]      src;
        logic [7:0]      dst;
        logic [1:0]      t;
    } beat_t;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int D     = (g == 0) ? 3 : (g == 1) ? 8 : 4;
        localparam int PM    = (g == 0) ? 0 : 1;
        localparam int TH    = (g == 2) ? 2 : D - 1;
        localparam int CWT   = $clog2(D + 1);
        localparam int LASTP = (g == 0) ? 1 : (g == 1) ? 3 : 7;

        logic           rst, flush, s_valid, s_ready, s_last, m_valid, m_ready, m_last, almost_full;
        logic [DW-1:0]   s_data, m_data;
        logic [DW/8-1:0] s_keep, s_strb, m_keep, m_strb;
        logic [7:0]      s_src, s_dst, m_src, m_dst;
        logic [1:0]      s_type, m_type;
        logic [CWT-1:0]  count, pkt_count;
        bit              fin = 1'b0;

        lii_stream_pkt_fifo #(
            .DW(DW), .SRC_W(8), .DST_W(8), .TYPE_W(2),
            .DEPTH(D), .PKT_MODE(PM), .AFULL_TH(TH)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush),
            .s_data(s_data), .s_keep(s_keep), .s_strb(s_strb), .s_last(s_last),
            .s_src(s_src), .s_dst(s_dst), .s_type(s_type),
            .s_valid(s_valid), .s_ready(s_ready),
            .m_data(m_data), .m_keep(m_keep), .m_strb(m_strb), .m_last(m_last),
            .m_src(m_src), .m_dst(m_dst), .m_type(m_type),
            .m_valid(m_valid), .m_ready(m_ready),
            .count(count), .pkt_count(pkt_count), .almost_full(almost_full)
        );

        // Reference model: queue of stored beats plus "a packet is part-way out".
        beat_t       sb[$];
        bit          mdrain = 1'b0;
        int unsigned wr_n   = 0;

        always @(negedge clk) begin
            int unsigned npk;
            bit          er, ev;
            beat_t       in_b;
            npk = 0;
            foreach (sb[i]) if (sb[i].l) npk++;
            er = (sb.size() < D) && !flush && !rst;
            if (PM != 0) ev = (npk != 0) || (sb.size() == D) || (mdrain && sb.size() != 0);
            else         ev = (sb.size() != 0);

            check($sformatf("cfg%0d s_ready", g), 64'(s_ready), 64'(er));
            check($sformatf("cfg%0d m_valid", g), 64'(m_valid), 64'(ev));
            check($sformatf("cfg%0d count", g), 64'(count), 64'(sb.size()));
            check($sformatf("cfg%0d pkt_count", g), 64'(pkt_count), 64'(npk));
            check($sformatf("cfg%0d almost_full", g), 64'(almost_full), 64'(sb.size() >= TH));
            check($sformatf("cfg%0d wr_idx", g), 64'(dut.wr_idx_q), 64'(wr_n));
            if (PM != 0) check($sformatf("cfg%0d draining", g), 64'(dut.draining_q), 64'(mdrain));
            if (ev) check($sformatf("cfg%0d beat", g),
                          64'({m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type}), 64'(sb[0]));

            in_b = {s_data, s_keep, s_strb, s_last, s_src, s_dst, s_type};
            if (rst || flush) begin
                sb.delete();
                mdrain = 1'b0;
                wr_n   = 0;
            end else begin
                if (ev && m_ready) begin
                    mdrain = !sb[0].l;
                    void'(sb.pop_front());
                end
                if (s_valid && er) begin
                    sb.push_back(in_b);
                    wr_n = (wr_n + 1) % D;
                end
            end
        end

        task automatic rnd_beat();
            s_data = $urandom;
            s_keep = 4'($urandom);
            s_strb = 4'($urandom);
            s_src  = 8'($urandom);
            s_dst  = 8'($urandom);
            s_type = 2'($urandom);
        endtask

        task automatic step(input bit sv, input bit lst, input bit mr, input bit fl, input bit rs);
            rnd_beat();
            s_valid = sv; s_last = lst; m_ready = mr; flush = fl; rst = rs;
            @(posedge clk); #1;
        endtask

        task automatic idle(input int n, input bit mr);
            for (int i = 0; i < n; i++) step(1'b0, 1'b0, mr, 1'b0, 1'b0);
        endtask

        // Hold one beat until the FIFO takes it, bounded.
        task automatic send(input bit lst, input bit mr);
            bit acc;
            int n;
            rnd_beat();
            s_valid = 1'b1; s_last = lst; m_ready = mr; flush = 1'b0; rst = 1'b0;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 32) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL cfg%0d send_timeout: s_ready stayed 0 for %0d cycles, want 1", g, n);
            end
            s_valid = 1'b0;
        endtask

        initial begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(2, 1'b0);
            if (g == 0) begin
                for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
                idle(3, 1'b1);
                for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                send(1'b1, 1'b1);
                idle(5, 1'b1);
            end else if (g == 1) begin
                send(1'b0, 1'b1);
                send(1'b0, 1'b1);
                send(1'b1, 1'b1);
                idle(6, 1'b1);
            end else begin
                for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
                send(1'b1, 1'b1);
                idle(6, 1'b1);
                for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
                idle(2, 1'b0);
                idle(6, 1'b1);
                send(1'b0, 1'b1);
                send(1'b0, 1'b1);
                step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                idle(2, 1'b1);
                send(1'b1, 1'b1);
                idle(3, 1'b1);
                step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
                idle(3, 1'b1);
            end
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, LASTP) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
                     $urandom_range(0, 150) == 0);
            end
            idle(2 * D + 4, 1'b1);
            fin = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && c < 20000) begin
            @(posedge clk);
            c++;
        end
        if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
            total++;
            bad++;
            $display("FAIL run_timeout: stimulus unfinished after %0d cycles, want done", c);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
